// File: rtl/gpio_cntrl_pkg.sv
// Shared register map, response codes and decode helpers for the gpio_cntrl AXI4-Lite slave.
package gpio_cntrl_pkg;

    localparam logic [31:0] ADDR_OUT      = 32'h00;
    localparam logic [31:0] ADDR_DIR      = 32'h04;
    localparam logic [31:0] ADDR_RISE_EN  = 32'h08;
    localparam logic [31:0] ADDR_FALL_EN  = 32'h0C;
    localparam logic [31:0] ADDR_IN       = 32'h10;
    localparam logic [31:0] ADDR_IRQ_STAT = 32'h14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        SEL_OUT, SEL_DIR, SEL_RISE_EN, SEL_FALL_EN, SEL_IN, SEL_IRQ_STAT, SEL_NONE
    } reg_sel_e;

    typedef enum logic [1:0] {W_IDLE, W_HOLD, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_RESP} rd_state_e;

    // Byte-lane bits addr[1:0] never select a register.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        logic [31:0] word;
        word = {addr[31:2], 2'b00};
        case (word)
            ADDR_OUT:      return SEL_OUT;
            ADDR_DIR:      return SEL_DIR;
            ADDR_RISE_EN:  return SEL_RISE_EN;
            ADDR_FALL_EN:  return SEL_FALL_EN;
            ADDR_IN:       return SEL_IN;
            ADDR_IRQ_STAT: return SEL_IRQ_STAT;
            default:       return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pin input synchroniser with edge detection; edges are masked until the sync chain
// has flushed after reset so pins already high at reset release raise no event.
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int ARM_CYC = SYNC_STAGES + 1;
    localparam int CNT_W   = $clog2(ARM_CYC + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_pipe;
    logic [WIDTH-1:0]                  prev;
    logic [CNT_W-1:0]                  arm_cnt;
    logic                              armed;

    assign s     = sync_pipe[SYNC_STAGES-1];
    assign armed = (arm_cnt == CNT_W'(ARM_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_pipe <= '0;
            prev      <= '0;
            arm_cnt   <= '0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pin};
            prev      <= s;
            if (!armed)
                arm_cnt <= arm_cnt + 1'b1;
        end
    end

    assign rise = s & ~prev & rise_en & {WIDTH{armed}};
    assign fall = ~s & prev & fall_en & {WIDTH{armed}};

endmodule

// File: rtl/gpio_cntrl_s00_axi_regs.sv
// AXI4-Lite register file for gpio_cntrl: pin out/dir/edge-enable registers, synchronised
// input view and a W1C edge status register driving a level interrupt.
module gpio_cntrl_s00_axi_regs
    import gpio_cntrl_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 5,
    parameter int GPIO_WIDTH           = 8,
    parameter int SYNC_STAGES          = 2
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_areset,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    input  logic [GPIO_WIDTH-1:0]               gpio_i,
    output logic [GPIO_WIDTH-1:0]               gpio_o,
    output logic [GPIO_WIDTH-1:0]               gpio_t,
    output logic                                irq
);

    localparam int DW = C_S00_AXI_DATA_WIDTH;
    localparam int AW = C_S00_AXI_ADDR_WIDTH;
    localparam int GW = GPIO_WIDTH;

    logic clk, rst;
    assign clk = s00_axi_aclk;
    assign rst = s00_axi_areset;

    wr_state_e w_state, w_next;
    rd_state_e r_state, r_next;

    logic          aw_held, w_held;
    logic [AW-1:0] aw_addr;
    logic [DW-1:0] w_data;
    logic [DW/8-1:0] w_strb;

    logic          aw_hs, w_hs, ar_hs, wr_fire;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data, be_mask, rd_word;
    logic [DW/8-1:0] wr_strb;
    logic [GW-1:0] wr_val, wr_mask, w1c;
    reg_sel_e      wr_sel, rd_sel;

    logic [GW-1:0] out_reg, dir_reg, rise_en, fall_en, irq_stat;
    logic [GW-1:0] pin_s, rise, fall;

    assign aw_hs = s00_axi_awvalid & s00_axi_awready;
    assign w_hs  = s00_axi_wvalid & s00_axi_wready;
    assign ar_hs = s00_axi_arvalid & s00_axi_arready;

    // A write fires once both halves are present, whether latched earlier or arriving now.
    assign wr_fire = (aw_held | aw_hs) & (w_held | w_hs);
    assign wr_addr = aw_held ? aw_addr : s00_axi_awaddr;
    assign wr_data = w_held ? w_data : s00_axi_wdata;
    assign wr_strb = w_held ? w_strb : s00_axi_wstrb;
    assign wr_sel  = decode_addr(32'(wr_addr));
    assign rd_sel  = decode_addr(32'(s00_axi_araddr));

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < DW/8; b++)
            be_mask[8*b +: 8] = {8{wr_strb[b]}};
    end

    assign wr_val  = wr_data[GW-1:0];
    assign wr_mask = be_mask[GW-1:0];
    assign w1c     = (wr_fire && wr_sel == SEL_IRQ_STAT) ? (wr_val & wr_mask) : '0;

    function automatic logic [GW-1:0] merge(input logic [GW-1:0] old);
        return (old & ~wr_mask) | (wr_val & wr_mask);
    endfunction

    // Write-channel FSM
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE, W_HOLD: begin
                if (wr_fire)             w_next = W_RESP;
                else if (aw_hs || w_hs)  w_next = W_HOLD;
            end
            W_RESP:  if (s00_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        s00_axi_awready = ~rst & ~aw_held & (w_state != W_RESP);
        s00_axi_wready  = ~rst & ~w_held & (w_state != W_RESP);
        s00_axi_bvalid  = (w_state == W_RESP);
    end

    // Read-channel FSM
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)          r_next = R_RESP;
            R_RESP:  if (s00_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        s00_axi_arready = ~rst & (r_state == R_IDLE);
        s00_axi_rvalid  = (r_state == R_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr       <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s00_axi_bresp <= RESP_OKAY;
        end else if (wr_fire) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s00_axi_bresp <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= s00_axi_awaddr;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s00_axi_wdata;
                w_strb <= s00_axi_wstrb;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_sel)
            SEL_OUT:      rd_word[GW-1:0] = out_reg;
            SEL_DIR:      rd_word[GW-1:0] = dir_reg;
            SEL_RISE_EN:  rd_word[GW-1:0] = rise_en;
            SEL_FALL_EN:  rd_word[GW-1:0] = fall_en;
            SEL_IN:       rd_word[GW-1:0] = pin_s;
            SEL_IRQ_STAT: rd_word[GW-1:0] = irq_stat;
            default:      rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s00_axi_rdata <= '0;
            s00_axi_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            s00_axi_rdata <= rd_word;
            s00_axi_rresp <= (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Register file; a new edge on a bit wins over a simultaneous W1C of that bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg  <= '0;
            dir_reg  <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            irq_stat <= '0;
            gpio_o   <= '0;
            gpio_t   <= '1;
            irq      <= 1'b0;
        end else begin
            if (wr_fire) begin
                case (wr_sel)
                    SEL_OUT:     out_reg <= merge(out_reg);
                    SEL_DIR:     dir_reg <= merge(dir_reg);
                    SEL_RISE_EN: rise_en <= merge(rise_en);
                    SEL_FALL_EN: fall_en <= merge(fall_en);
                    default:     ;
                endcase
            end
            irq_stat <= (irq_stat & ~w1c) | rise | fall;
            gpio_o   <= out_reg;
            gpio_t   <= ~dir_reg;
            irq      <= |irq_stat;
        end
    end

    gpio_sync_edge #(
        .WIDTH       (GW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .pin     (gpio_i),
        .rise_en (rise_en),
        .fall_en (fall_en),
        .s       (pin_s),
        .rise    (rise),
        .fall    (fall)
    );

    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, wr_data, be_mask};

endmodule
